// File: rtl/ibex_prefetch_pkg.sv
// Shared types, default sizes and helpers for the N-request prefetch buffer.
package ibex_prefetch_pkg;

    localparam int unsigned PREFETCH_NUM_REQS   = 2;
    localparam int unsigned PREFETCH_FIFO_DEPTH = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    // Bits needed to hold a count in the range 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ibex_prefetch_fifo.sv
// Circular word queue for the prefetch buffer; tracks the word address of its head entry.
module ibex_prefetch_fifo
    import ibex_prefetch_pkg::*;
#(
    parameter int unsigned  FifoDepth = PREFETCH_FIFO_DEPTH,
    parameter bit           ResetAll  = 1'b0,
    localparam int unsigned CntW      = cnt_width(FifoDepth)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic [31:0]     clear_addr_i,
    input  logic            push_i,
    input  fetch_entry_t    wdata_i,
    input  logic            pop_i,
    output logic            valid_o,
    output fetch_entry_t    rdata_o,
    output logic [31:0]     addr_o,
    output logic [CntW-1:0] cnt_o
);

    localparam int unsigned     PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);

    fetch_entry_t    mem_q [FifoDepth];
    logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     head_addr_q, head_addr_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (cnt_q != '0);
    assign do_pop  = pop_i & valid_o & ~clear_i;
    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_push = push_i & ~clear_i & ((cnt_q != FullCnt) | do_pop);

    always_comb begin
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        head_addr_d = head_addr_q;
        if (clear_i) begin
            rptr_d      = '0;
            wptr_d      = '0;
            cnt_d       = '0;
            head_addr_d = clear_addr_i & 32'hFFFF_FFFC;
        end else begin
            if (do_push) wptr_d = ptr_inc(wptr_q);
            if (do_pop) begin
                rptr_d      = ptr_inc(rptr_q);
                head_addr_d = head_addr_q + 32'd4;
            end
            if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    if (ResetAll) begin : g_data_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                head_addr_q <= '0;
                for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
            end else begin
                head_addr_q <= head_addr_d;
                if (do_push) mem_q[wptr_q] <= wdata_i;
            end
        end
    end else begin : g_data_nrst
        always_ff @(posedge clk_i) begin
            head_addr_q <= head_addr_d;
            if (do_push) mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign addr_o  = head_addr_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/ibex_prefetch_buffer_nreq.sv
// Instruction prefetch buffer: up to NumReqs fetches in flight, FifoDepth buffered words.
// Defining IBEX_PREFETCH_PERF_EN adds saturating discard/stall counters.
module ibex_prefetch_buffer_nreq
    import ibex_prefetch_pkg::*;
#(
    parameter int unsigned NumReqs   = PREFETCH_NUM_REQS,
    parameter int unsigned FifoDepth = PREFETCH_FIFO_DEPTH,
    parameter bit          ResetAll  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        instr_rvalid_i,
`ifdef IBEX_PREFETCH_PERF_EN
    input  logic        perf_clr_i,
    output logic [15:0] perf_discard_o,
    output logic [15:0] perf_stall_o,
`endif
    output logic        busy_o
);

    localparam int unsigned OutW  = cnt_width(NumReqs);
    localparam int unsigned FifoW = cnt_width(FifoDepth);
    localparam int unsigned SumW  = cnt_width(NumReqs + FifoDepth);

    logic [OutW-1:0]  out_cnt_q, out_cnt_d, disc_cnt_q, disc_cnt_d, disc_base;
    logic             pend_q, pend_d, pend_disc_q, pend_disc_d;
    logic [31:0]      stored_addr_q, stored_addr_d, fetch_addr_q, fetch_addr_d;
    logic [31:0]      branch_addr, req_addr;
    logic [FifoW-1:0] fifo_cnt;
    logic             room, new_req, gnt_acc, rsp, drop_rsp, push;
    fetch_entry_t     push_entry, head_entry;

    assign branch_addr = addr_i & 32'hFFFF_FFFC;
    assign room        = (SumW'(fifo_cnt) + SumW'(out_cnt_q)) < SumW'(FifoDepth);
    assign new_req     = req_i & (out_cnt_q < OutW'(NumReqs)) & (room | branch_i);

    assign instr_req_o  = pend_q | new_req;
    assign req_addr     = pend_q ? stored_addr_q : (branch_i ? branch_addr : fetch_addr_q);
    assign instr_addr_o = req_addr & 32'hFFFF_FFFC;

    assign gnt_acc  = instr_req_o & instr_gnt_i;
    // Responses without an outstanding request are ignored so the counters cannot wrap.
    assign rsp      = instr_rvalid_i & (out_cnt_q != '0);
    assign drop_rsp = rsp & (branch_i | (disc_cnt_q != '0));
    assign push     = rsp & ~drop_rsp;

    always_comb begin
        out_cnt_d = out_cnt_q + OutW'(gnt_acc) - OutW'(rsp);

        disc_base = disc_cnt_q;
        if (branch_i)                     disc_base = out_cnt_q - OutW'(rsp);
        else if (rsp && disc_cnt_q != '0) disc_base = disc_cnt_q - 1'b1;
        // A held request that straddled a branch fetches a stale address: drop its response.
        disc_cnt_d = disc_base + OutW'(gnt_acc & pend_q & (pend_disc_q | branch_i));

        pend_d        = instr_req_o & ~instr_gnt_i;
        pend_disc_d   = pend_q & ~instr_gnt_i & (pend_disc_q | branch_i);
        stored_addr_d = pend_d ? instr_addr_o : stored_addr_q;

        fetch_addr_d = fetch_addr_q;
        if (new_req && !pend_q) fetch_addr_d = instr_addr_o + 32'd4;
        else if (branch_i)      fetch_addr_d = branch_addr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_q   <= '0;
            disc_cnt_q  <= '0;
            pend_q      <= 1'b0;
            pend_disc_q <= 1'b0;
        end else begin
            out_cnt_q   <= out_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
            pend_q      <= pend_d;
            pend_disc_q <= pend_disc_d;
        end
    end

    if (ResetAll) begin : g_addr_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stored_addr_q <= '0;
                fetch_addr_q  <= '0;
            end else begin
                stored_addr_q <= stored_addr_d;
                fetch_addr_q  <= fetch_addr_d;
            end
        end
    end else begin : g_addr_nrst
        always_ff @(posedge clk_i) begin
            stored_addr_q <= stored_addr_d;
            fetch_addr_q  <= fetch_addr_d;
        end
    end

    assign push_entry = '{rdata: instr_rdata_i, err: instr_err_i};

    ibex_prefetch_fifo #(
        .FifoDepth (FifoDepth),
        .ResetAll  (ResetAll)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (branch_i),
        .clear_addr_i (branch_addr),
        .push_i       (push),
        .wdata_i      (push_entry),
        .pop_i        (ready_i),
        .valid_o      (valid_o),
        .rdata_o      (head_entry),
        .addr_o       (addr_o),
        .cnt_o        (fifo_cnt)
    );

    assign rdata_o = head_entry.rdata;
    assign err_o   = valid_o & head_entry.err;
    assign busy_o  = instr_req_o | (out_cnt_q != '0);

`ifdef IBEX_PREFETCH_PERF_EN
    logic [15:0] perf_discard_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_discard_q <= '0;
            perf_stall_q   <= '0;
        end else if (perf_clr_i) begin
            perf_discard_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (drop_rsp && perf_discard_q != 16'hFFFF)        perf_discard_q <= perf_discard_q + 16'd1;
            if (req_i && !valid_o && perf_stall_q != 16'hFFFF) perf_stall_q   <= perf_stall_q + 16'd1;
        end
    end

    assign perf_discard_o = perf_discard_q;
    assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ibex_prefetch_buffer_nreq.sv
// Scoreboard bench for ibex_prefetch_buffer_nreq: random bus model plus directed scenarios.
module tb_ibex_prefetch_buffer_nreq;
    import ibex_prefetch_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned FD = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni, req_i, branch_i, ready_i;
    logic [31:0] addr_i;
    logic        valid_o, err_o, instr_req_o, busy_o;
    logic [31:0] rdata_o, addr_o, instr_addr_o;
    logic        instr_gnt_i, instr_err_i, instr_rvalid_i;
    logic [31:0] instr_rdata_i;
`ifdef IBEX_PREFETCH_PERF_EN
    logic        perf_clr_i;
    logic [15:0] perf_discard_o, perf_stall_o;
`endif

    always #5 clk_i = ~clk_i;

    ibex_prefetch_buffer_nreq #(.NumReqs(NR), .FifoDepth(FD), .ResetAll(1'b0)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .err_o          (err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .instr_rvalid_i (instr_rvalid_i),
`ifdef IBEX_PREFETCH_PERF_EN
        .perf_clr_i     (perf_clr_i),
        .perf_discard_o (perf_discard_o),
        .perf_stall_o   (perf_stall_o),
`endif
        .busy_o         (busy_o)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          gnt_pct = 100;
    int          rv_pct = 100;
    int          total_gnt = 0;
    int          gnt_base;
    logic [31:0] bus_q[$];
    logic [31:0] exp_q[$];

    // Memory contents and error flags are pure functions of the word address.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return (a[5:2] == 4'hF);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // After a branch the consumer must see consecutive words from the aligned target.
    task automatic do_branch(input logic [31:0] a, input int n);
        logic [31:0] t;
        t = a & 32'hFFFF_FFFC;
        branch_i = 1'b1;
        addr_i   = a;
        req_i    = 1'b1;
        ready_i  = 1'b0;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(t + 32'(4 * k));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (valid_o !== 1'b1 && n < 40) begin
            @(posedge clk_i);
            #3;
            n++;
        end
        if (valid_o !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: valid_o timeout got %b expected 1", nm, valid_o);
        end
    endtask

    // Bus slave: random grants, in-order responses after at least one cycle.
    initial begin
        logic [31:0] a;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            instr_gnt_i = (int'($urandom_range(99)) < gnt_pct);
            if (!rst_ni) begin
                bus_q.delete();
                instr_rvalid_i = 1'b0;
            end else if (bus_q.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
                a              = bus_q.pop_front();
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = data_of(a);
                instr_err_i    = err_of(a);
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = $urandom;
                instr_err_i    = 1'($urandom);
            end
        end
    end

    // Monitor: bus protocol checks and scoreboard pops on every accepted output word.
    initial begin
        logic        prev_pend;
        logic [31:0] prev_addr, e;
        prev_pend = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("held_req", instr_req_o, 1'b1);
                    chk("held_addr", instr_addr_o, prev_addr);
                end
                if (instr_req_o && instr_gnt_i) begin
                    chk("req_align", instr_addr_o[1:0], 2'b00);
                    bus_q.push_back(instr_addr_o);
                    total_gnt++;
                    chk("outstanding_le_numreqs", (bus_q.size() + int'(instr_rvalid_i)) <= NR, 1'b1);
                end
                prev_pend = instr_req_o & ~instr_gnt_i;
                prev_addr = instr_addr_o;
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pop_unexpected: got addr %h expected no output", addr_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_addr", addr_o, e);
                        chk("pop_data", rdata_o, data_of(e));
                        chk("pop_err", err_o, err_of(e));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          len;
        rst_ni   = 1'b0;
        req_i    = 1'b0;
        branch_i = 1'b0;
        addr_i   = '0;
        ready_i  = 1'b0;
`ifdef IBEX_PREFETCH_PERF_EN
        perf_clr_i = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        #3;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_req", instr_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        step();
        rst_ni = 1'b1;

        // Cold start with single-cycle grant and next-cycle response.
        step();
        gnt_base = total_gnt;
        do_branch(32'h80, 16);
        #2;
        chk("cold_req0", instr_req_o, 1'b1);
        chk("cold_addr0", instr_addr_o, 32'h80);
        chk("cold_valid0", valid_o, 1'b0);
        step();
        branch_i = 1'b0;
        #2;
        chk("cold_addr1", instr_addr_o, 32'h84);
        chk("cold_valid1", valid_o, 1'b0);
        step();
        #2;
        chk("cold_addr2", instr_addr_o, 32'h88);
        chk("cold_valid2", valid_o, 1'b1);
        chk("cold_head", addr_o, 32'h80);

        // Back-pressure: the queue plus in-flight fetches fill, then one pop frees one slot.
        repeat (6) step();
        #2;
        chk("bp_req_idle", instr_req_o, 1'b0);
        chk("bp_grants", total_gnt - gnt_base, 3);
        step();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        repeat (6) step();
        #2;
        chk("bp_grants_after_pop", total_gnt - gnt_base, 4);
        chk("bp_req_idle2", instr_req_o, 1'b0);

        // Branch with two fetches in flight.
        step();
        rv_pct  = 0;
        ready_i = 1'b1;
        repeat (8) step();
        #2;
        chk("br2_busy", busy_o, 1'b1);
        step();
        do_branch(32'h200, 16);
        #2;
        chk("br2_no_req_when_full", instr_req_o, 1'b0);
        step();
        branch_i = 1'b0;
        rv_pct   = 100;
        #2;
        chk("br2_valid_c1", valid_o, 1'b0);
        step();
        #2;
        chk("br2_valid_c2", valid_o, 1'b0);
        step();
        #2;
        chk("br2_valid_c3", valid_o, 1'b0);
        wait_valid("br2_wait");
        chk("br2_head", addr_o, 32'h200);
`ifdef IBEX_PREFETCH_PERF_EN
        chk("perf_discard", perf_discard_o, 16'd2);
        step();
        perf_clr_i = 1'b1;
        step();
        perf_clr_i = 1'b0;
        #2;
        chk("perf_clr_discard", perf_discard_o, 16'd0);
        chk("perf_clr_stall", perf_stall_o, 16'd0);
`endif

        // Held request across a branch.
        step();
        req_i = 1'b0;
        repeat (5) step();
        gnt_pct = 0;
        do_branch(32'h500, 16);
        step();
        branch_i = 1'b0;
        step();
        do_branch(32'h600, 16);
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("held_req_dir", instr_req_o, 1'b1);
            chk("held_addr_dir", instr_addr_o, 32'h500);
            step();
            branch_i = 1'b0;
        end
        gnt_pct = 100;
        #2;
        chk("held_gnt_addr", instr_addr_o, 32'h500);
        step();
        #2;
        chk("held_next_req", instr_req_o, 1'b1);
        chk("held_next_addr", instr_addr_o, 32'h600);
        wait_valid("held_wait");
        chk("held_head", addr_o, 32'h600);

        // Wrap-around and error flag.
        step();
        req_i = 1'b0;
        repeat (5) step();
        do_branch(32'hFFFF_FFFE, 16);
        step();
        branch_i = 1'b0;
        #2;
        wait_valid("wrap_wait0");
        chk("wrap_addr0", addr_o, 32'hFFFF_FFFC);
        chk("wrap_err0", err_o, 1'b1);
        step();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        #2;
        wait_valid("wrap_wait1");
        chk("wrap_addr1", addr_o, 32'h0);
        chk("wrap_err1", err_o, 1'b0);

        // Asynchronous reset with two fetches in flight.
        step();
        req_i = 1'b0;
        repeat (5) step();
        rv_pct = 0;
        do_branch(32'h700, 16);
        step();
        branch_i = 1'b0;
        repeat (3) step();
        #2;
        chk("rstmid_busy_before", busy_o, 1'b1);
        step();
        rst_ni = 1'b0;
        req_i  = 1'b0;
        #2;
        chk("rstmid_busy", busy_o, 1'b0);
        chk("rstmid_valid", valid_o, 1'b0);
        chk("rstmid_req", instr_req_o, 1'b0);
        repeat (2) step();
        rst_ni = 1'b1;
        step();

        // Randomised segments: each starts with a branch, random bus timing and consumer.
        for (int seg = 0; seg < 14; seg++) begin
            a = $urandom;
            if ($urandom_range(3) == 0) a = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            gnt_pct = int'($urandom_range(100, 40));
            rv_pct  = int'($urandom_range(100, 30));
            len     = int'($urandom_range(40, 20));
            do_branch(a, 64);
            for (int k = 0; k < len; k++) begin
                step();
                branch_i = 1'b0;
                req_i    = ($urandom_range(9) != 0);
                ready_i  = ($urandom_range(99) < 70);
            end
            step();
        end
        req_i   = 1'b0;
        ready_i = 1'b1;
        gnt_pct = 100;
        rv_pct  = 100;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
